// File: rtl/register_bus_reader_pkg.sv
// Shared types and helpers for the register bus reader.
package reg_bus_pkg;

    // Scan FSM encoding; DRIVE selects one register, WAIT_OUT offers the captured word.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_WAIT_OUT = 2'd2
    } state_t;

    // Ceiling log2; clog2(1)=0, clog2(2)=1, clog2(3)=2.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/register_bus_reader_if.sv
// Register bus and output stream of the register bus reader.
//
// Stream handshake: the reader raises OutValid with OutData/OutIndex and keeps
// all three stable until a transfer, which happens on a qualified edge
// (Tick=1) where OutValid=1 and OutReady=1. OutReady may toggle freely and
// never combinationally depends on OutValid being low.
interface register_bus_reader_if #(
    parameter int NrOfBits  = 8,
    parameter int NrOfRegs  = 16,
    parameter int IndexBits = 4
);
    logic [NrOfBits-1:0]  Bus;
    logic [NrOfRegs-1:0]  Cs;
    logic [NrOfBits-1:0]  OutData;
    logic [IndexBits-1:0] OutIndex;
    logic                 OutValid;
    logic                 OutReady;

    // Reader side: selects registers, samples Bus, sources the stream.
    modport master (
        input  Bus,
        input  OutReady,
        output Cs,
        output OutData,
        output OutIndex,
        output OutValid
    );

    // Environment side: register bank drives Bus, consumer drives OutReady.
    modport slave (
        output Bus,
        output OutReady,
        input  Cs,
        input  OutData,
        input  OutIndex,
        input  OutValid
    );
endinterface

// File: rtl/register_bus_reader_cs_decoder.sv
// One-hot-cold chip-select decoder: bit idx_i low when enabled, all ones otherwise.
module cs_decoder #(
    parameter int NrOfRegs  = 16,
    parameter int IndexBits = 4
) (
    input  logic [IndexBits-1:0] idx_i,
    input  logic                 en_i,
    output logic [NrOfRegs-1:0]  cs_o
);

    // Decode the index; an index outside the bank selects nothing.
    always_comb begin
        cs_o = '1;
        if (en_i) begin
            for (int i = 0; i < NrOfRegs; i++) begin
                if (idx_i == IndexBits'(i)) begin
                    cs_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/register_bus_reader.sv
// Scans a bank of tristate registers one at a time and streams each word
// out tagged with its register index.
module register_bus_reader
    import reg_bus_pkg::*;
#(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 16,
    parameter int IndexBits    = 4,
    parameter int SettleCycles = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Tick,
    input  logic                  Start,
    input  logic                  Abort,
    register_bus_reader_if.master bus_if,
    output logic                  Busy,
    output logic                  Done,
    output state_t                DbgState
);

    localparam int CntBitsRaw = clog2(SettleCycles + 1);
    localparam int CntBits    = (CntBitsRaw < 1) ? 1 : CntBitsRaw;

    localparam logic [IndexBits-1:0] LastIdx    = IndexBits'(NrOfRegs - 1);
    localparam logic [CntBits-1:0]   SettleInit = CntBits'(SettleCycles);

    state_t               state_q, state_d;
    logic [IndexBits-1:0] idx_q, idx_d;
    logic [CntBits-1:0]   cnt_q, cnt_d;
    logic [NrOfBits-1:0]  data_q, data_d;
    logic [IndexBits-1:0] index_q, index_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    logic [NrOfRegs-1:0]  cs;

    // Next-state logic: Abort acts on any edge, everything else waits for Tick.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        done_d  = 1'b0;   // Done is a single-cycle pulse independent of Tick

        if (Abort) begin
            // Captured data/index are kept; only the handshake is dropped.
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (Tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_d = ST_DRIVE;
                        idx_d   = '0;
                        cnt_d   = SettleInit;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        data_d  = bus_if.Bus;
                        index_d = idx_q;
                        valid_d = 1'b1;
                        state_d = ST_WAIT_OUT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_WAIT_OUT: begin
                    if (valid_q && bus_if.OutReady) begin
                        valid_d = 1'b0;
                        if (idx_q == LastIdx) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            cnt_d   = SettleInit;
                            state_d = ST_DRIVE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Only DRIVE selects a register, so WAIT_OUT always separates two selects.
    cs_decoder #(
        .NrOfRegs  (NrOfRegs),
        .IndexBits (IndexBits)
    ) u_cs_decoder (
        .idx_i (idx_q),
        .en_i  (state_q == ST_DRIVE),
        .cs_o  (cs)
    );

    assign bus_if.Cs       = cs;
    assign bus_if.OutData  = data_q;
    assign bus_if.OutIndex = index_q;
    assign bus_if.OutValid = valid_q;

    assign Busy     = (state_q != ST_IDLE);
    assign Done     = done_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_register_bus_reader.sv
// Directed bench for register_bus_reader with a four-register bank.
module tb_register_bus_reader;
    import reg_bus_pkg::*;

    localparam int NB = 8;
    localparam int NR = 4;
    localparam int IB = 2;
    localparam int W  = IB + NB;

    logic   clk;
    logic   Reset;
    logic   Tick;
    logic   Start;
    logic   Abort;
    logic   Busy;
    logic   Done;
    state_t DbgState;

    register_bus_reader_if #(.NrOfBits(NB), .NrOfRegs(NR), .IndexBits(IB)) bif ();

    register_bus_reader #(
        .NrOfBits     (NB),
        .NrOfRegs     (NR),
        .IndexBits    (IB),
        .SettleCycles (1)
    ) dut (
        .Clock    (clk),
        .Reset    (Reset),
        .Tick     (Tick),
        .Start    (Start),
        .Abort    (Abort),
        .bus_if   (bif.master),
        .Busy     (Busy),
        .Done     (Done),
        .DbgState (DbgState)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register bank model; 0xEE marks an undriven bus.
    always_comb begin
        case (bif.Cs)
            4'b1110: bif.Bus = 8'h11;
            4'b1101: bif.Bus = 8'h22;
            4'b1011: bif.Bus = 8'h33;
            4'b0111: bif.Bus = 8'h44;
            default: bif.Bus = 8'hEE;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tick_mode = 0;
    int done_cnt = 0;
    int multi_cs_cnt = 0;
    int extra_beats  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge.
    state_t prev_state;
    logic   prev_tick;
    logic   prev_ok = 1'b0;
    always @(negedge clk) begin
        if (!Reset) begin
            if ($countones(~bif.Cs) > 1) multi_cs_cnt++;
            if (bif.OutValid && bif.OutReady && Tick && !Abort) begin
                if (exp_q.size() == 0) begin
                    extra_beats++;
                end else begin
                    check("beat", 32'({bif.OutIndex, bif.OutData}), 32'(exp_q.pop_front()));
                end
            end
            if (Done) done_cnt++;
            if (tick_mode != 0 && prev_ok && !prev_tick) begin
                check("hold_without_tick", 32'(DbgState), 32'(prev_state));
            end
            prev_state = DbgState;
            prev_tick  = Tick;
            prev_ok    = !Abort;
        end else begin
            prev_ok = 1'b0;
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        Tick = (tick_mode != 0) ? ((cyc % 3) == 0) : 1'b1;
    endtask

    task automatic push_beats(input int first, input int last);
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = first; i <= last; i++) begin
            exp_q.push_back({IB'(i), vals[i]});
        end
    endtask

    task automatic start_scan();
        int n;
        n = 0;
        Start = 1'b1;
        do begin
            step();
            n++;
        end while (!Busy && n < 50);
        Start = 1'b0;
        check("start_accepted", 32'(Busy), 32'd1);
    endtask

    task automatic wait_done(input int done_before);
        int n;
        n = 0;
        while (done_cnt == done_before && n < 400) begin
            step();
            n++;
        end
        step();
        step();
        check("done_pulses", 32'(done_cnt - done_before), 32'd1);
    endtask

    task automatic wait_cs(input logic [3:0] v);
        int n;
        n = 0;
        while (bif.Cs !== v && n < 200) begin
            step();
            n++;
        end
        check("wait_cs", 32'(bif.Cs), 32'(v));
    endtask

    task automatic scan_checks(input string tag);
        check({tag, "_all_beats"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_extra_beats"}, 32'(extra_beats), 32'd0);
        check({tag, "_one_cs_low"}, 32'(multi_cs_cnt), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        Reset = 1'b1; Tick = 1'b1; Start = 1'b0; Abort = 1'b0;
        bif.OutReady = 1'b1;

        // 1: reset values
        step(); step();
        Reset = 1'b0;
        check("rst_cs", 32'(bif.Cs), 32'hF);
        check("rst_valid", 32'(bif.OutValid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_data", 32'(bif.OutData), 32'd0);
        check("rst_index", 32'(bif.OutIndex), 32'd0);
        step();
        check("rst_state", 32'(DbgState), 32'(ST_IDLE));

        // 2: full scan, latency of the first beat
        d0 = done_cnt;
        push_beats(0, 3);
        start_scan();
        check("lat_cs0_first", 32'(bif.Cs), 32'hE);
        step();
        check("lat_cs0_settle", 32'(bif.Cs), 32'hE);
        step();
        check("lat_cap_valid", 32'(bif.OutValid), 32'd1);
        check("lat_cap_data", 32'(bif.OutData), 32'h11);
        check("lat_cap_cs", 32'(bif.Cs), 32'hF);
        wait_done(d0);
        scan_checks("scan");

        // 3: backpressure on beat 1
        d0 = done_cnt;
        push_beats(0, 3);
        start_scan();
        n = 0;
        while (!(bif.OutValid && bif.OutIndex == 2'd1) && n < 50) begin
            step();
            n++;
        end
        bif.OutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_data", 32'(bif.OutData), 32'h22);
            check("bp_index", 32'(bif.OutIndex), 32'd1);
            check("bp_cs", 32'(bif.Cs), 32'hF);
            check("bp_valid", 32'(bif.OutValid), 32'd1);
        end
        bif.OutReady = 1'b1;
        wait_done(d0);
        scan_checks("bp");

        // 4: Tick every third cycle
        tick_mode = 1;
        d0 = done_cnt;
        push_beats(0, 3);
        start_scan();
        wait_done(d0);
        scan_checks("tick");
        tick_mode = 0;
        step();

        // 5: abort while register 2 is selected, then rescan
        d0 = done_cnt;
        push_beats(0, 1);
        start_scan();
        wait_cs(4'b1011);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("abort_cs", 32'(bif.Cs), 32'hF);
        check("abort_valid", 32'(bif.OutValid), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_data_held", 32'(bif.OutData), 32'h22);
        check("abort_index_held", 32'(bif.OutIndex), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_still_idle", 32'(DbgState), 32'(ST_IDLE));
        scan_checks("abort");
        d0 = done_cnt;
        push_beats(0, 3);
        start_scan();
        check("rescan_cs0", 32'(bif.Cs), 32'hE);
        wait_done(d0);
        scan_checks("rescan");

        // 6: Start while busy is ignored; Start with Reset stays idle
        d0 = done_cnt;
        push_beats(0, 3);
        start_scan();
        step(); step(); step();
        Start = 1'b1;
        step(); step();
        Start = 1'b0;
        wait_done(d0);
        scan_checks("busy_start");
        Reset = 1'b1;
        Start = 1'b1;
        step();
        Reset = 1'b0;
        Start = 1'b0;
        step();
        check("rst_start_busy", 32'(Busy), 32'd0);
        check("rst_start_cs", 32'(bif.Cs), 32'hF);
        check("rst_start_data", 32'(bif.OutData), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
